point_sequencer: RTL

POINT_SEQUENCER -- requirements
Module: point_sequencer

---
 rtl/point_sequencer_if.sv | 23 ++
 rtl/point_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/point_sequencer_if.sv
// Point-buffer read port and DAC output bundle for the vector point sequencer.
interface point_sequencer_if;
  logic        drawing;
  logic [10:0] num_pts;
  logic [29:0] point;
  logic [10:0] index;
  logic        done_drawing;
  logic [11:0] x;
  logic [11:0] y;
  logic [5:0]  z;
  logic        dac_strobe;
  logic        busy;

  modport master (
    input  drawing, num_pts, point,
    output index, done_drawing, x, y, z, dac_strobe, busy
  );

  modport slave (
    output drawing, num_pts, point,
    input  index, done_drawing, x, y, z, dac_strobe, busy
  );
endinterface

// File: rtl/point_sequencer.sv
// Walks a frame of points out of a buffer and drives x/y/z DAC codes,
// holding lit points DWELL cycles and blanked points BLANK_DWELL cycles.
module point_sequencer #(
  parameter int DWELL       = 8,
  parameter int BLANK_DWELL = 32
) (
  input logic               clk,
  input logic               reset,
  point_sequencer_if.master bus
);

  localparam int MAXD = (DWELL > BLANK_DWELL) ? DWELL : BLANK_DWELL;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_DWELL, S_DONE} state_t;

  state_t      state;
  logic        armed;
  logic [10:0] npts;
  logic [10:0] index;
  logic [CW-1:0] cnt;
  logic [11:0] x, y;
  logic [5:0]  z;
  logic        dac_strobe, done_drawing, busy;

  assign bus.index        = index;
  assign bus.x            = x;
  assign bus.y            = y;
  assign bus.z            = z;
  assign bus.dac_strobe   = dac_strobe;
  assign bus.done_drawing = done_drawing;
  assign bus.busy         = busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      armed        <= 1'b0;
      npts         <= '0;
      index        <= '0;
      cnt          <= '0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      dac_strobe   <= 1'b0;
      done_drawing <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dac_strobe   <= 1'b0;
      done_drawing <= 1'b0;
      case (state)
        S_IDLE: begin
          // armed only re-arms after drawing is seen low here, so a slow
          // falling drawing after a frame cannot replay it
          if (!bus.drawing) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            busy  <= 1'b1;
            if (bus.num_pts != 11'd0) begin
              npts  <= bus.num_pts;
              index <= '0;
              state <= S_FETCH;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_drawing <= 1'b1;
          z            <= '0;
          index        <= '0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          if (!bus.drawing) begin
            z     <= '0;
            index <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            case (state)
              S_FETCH: state <= S_LOAD;
              S_LOAD: begin
                x          <= bus.point[29:18];
                y          <= bus.point[17:6];
                z          <= bus.point[5:0];
                dac_strobe <= 1'b1;
                cnt        <= (bus.point[5:0] != 6'd0) ? CW'(DWELL) : CW'(BLANK_DWELL);
                state      <= S_DWELL;
              end
              default: begin
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                  if (index == npts - 11'd1) begin
                    state <= S_DONE;
                  end else begin
                    index <= index + 11'd1;
                    state <= S_FETCH;
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
